// File: rtl/div_reconstructor_pkg.sv
// Shared definitions for the divide-result reconstructor.
// Optional check port pair is enabled by defining DIV_RECON_CHECK_EN.
package div_recon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DIV_RECON_WIDTH = 32;

  // Packed divider word: {remainder, quotient}; quotient in the low half.
  localparam int unsigned QUO_OFFSET = 0;

  function automatic int unsigned rem_offset(input int unsigned w);
    return w;
  endfunction

  // Iteration counter must hold W-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_reconstructor_if.sv
// Handshake/data bundle between a divide-result source and the reconstructor.
// opera2/mismatch exist only when DIV_RECON_CHECK_EN is defined.
interface div_reconstructor_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     opera1;
  logic [2*WIDTH-1:0]   result;
  logic [2*WIDTH-1:0]   dividend;
  logic                 valid;
`ifdef DIV_RECON_CHECK_EN
  logic [2*WIDTH-1:0]   opera2;
  logic                 mismatch;

  modport master (
    output start, opera1, result, opera2,
    input  dividend, valid, mismatch
  );

  modport slave (
    input  start, opera1, result, opera2,
    output dividend, valid, mismatch
  );
`else
  modport master (
    output start, opera1, result,
    input  dividend, valid
  );

  modport slave (
    input  start, opera1, result,
    output dividend, valid
  );
`endif
endinterface

// File: rtl/div_reconstructor_sign_mag.sv
// Two's-complement word to sign bit plus unsigned magnitude.
// The most negative value maps to magnitude 2^(W-1) without overflow.
module sign_mag #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic             sign,
  output logic [WIDTH-1:0] mag
);

  // Negate negative inputs; the unsigned result covers the full range.
  always_comb begin
    sign = value[WIDTH-1];
    mag  = sign ? (~value + 1'b1) : value;
  end

endmodule

// File: rtl/div_reconstructor.sv
// Rebuilds a signed dividend from {remainder, quotient} and the divisor:
// dividend = quotient*divisor + remainder, via a radix-2 shift-add
// multiplier on magnitudes, then one sign-fix/remainder-add cycle.
// Defining DIV_RECON_CHECK_EN adds an expected-dividend compare.
module div_reconstructor
  import div_recon_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_RECON_WIDTH
) (
  input logic                clock,
  input logic                reset,
  div_reconstructor_if.slave bus
);

  localparam int unsigned CW      = cnt_width(WIDTH);
  localparam int unsigned REM_LSB = rem_offset(WIDTH);

  state_t               state;
  logic                 start_q;
  logic                 launch;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   rem_ext;
  logic                 neg;
  logic [2*WIDTH-1:0]   fix_value;
  logic [2*WIDTH-1:0]   dividend_r;
  logic                 valid_r;

  logic [WIDTH-1:0]     quo_word;
  logic [WIDTH-1:0]     rem_word;
  logic                 div_sign;
  logic                 quo_sign;
  logic [WIDTH-1:0]     div_mag;
  logic [WIDTH-1:0]     quo_mag;

`ifdef DIV_RECON_CHECK_EN
  logic [2*WIDTH-1:0]   expect_q;
  logic                 mismatch_r;
`endif

  // Unpack the divider word.
  always_comb begin
    quo_word = bus.result[QUO_OFFSET +: WIDTH];
    rem_word = bus.result[REM_LSB +: WIDTH];
  end

  sign_mag #(.WIDTH(WIDTH)) u_div_mag (
    .value (bus.opera1),
    .sign  (div_sign),
    .mag   (div_mag)
  );

  sign_mag #(.WIDTH(WIDTH)) u_quo_mag (
    .value (quo_word),
    .sign  (quo_sign),
    .mag   (quo_mag)
  );

  // Launch on a sampled rising edge of start while idle or finished.
  always_comb begin
    launch = bus.start & ~start_q & ((state == IDLE) | (state == DONE));
  end

  // Signed product plus remainder, wrapping modulo 2^(2W).
  always_comb begin
    fix_value = (neg ? (~acc + 1'b1) : acc) + rem_ext;
  end

  // Control FSM together with the shift-add datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      rem_ext    <= '0;
      neg        <= 1'b0;
      dividend_r <= '0;
      valid_r    <= 1'b0;
`ifdef DIV_RECON_CHECK_EN
      expect_q   <= '0;
      mismatch_r <= 1'b0;
`endif
    end else begin
      start_q <= bus.start;
      unique case (state)
        IDLE, DONE: begin
          if (launch) begin
            mcand   <= {{WIDTH{1'b0}}, div_mag};
            mplier  <= quo_mag;
            neg     <= div_sign ^ quo_sign;
            rem_ext <= {{WIDTH{rem_word[WIDTH-1]}}, rem_word};
            acc     <= '0;
            cnt     <= CW'(WIDTH - 1);
            valid_r <= 1'b0;
`ifdef DIV_RECON_CHECK_EN
            expect_q   <= bus.opera2;
            mismatch_r <= 1'b0;
`endif
            state   <= MUL;
          end
        end
        MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          dividend_r <= fix_value;
          valid_r    <= 1'b1;
`ifdef DIV_RECON_CHECK_EN
          mismatch_r <= (fix_value != expect_q);
`endif
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dividend = dividend_r;
  assign bus.valid    = valid_r;
`ifdef DIV_RECON_CHECK_EN
  assign bus.mismatch = mismatch_r;
`endif

endmodule

// File: tb/tb_div_reconstructor.sv
// Directed bench for div_reconstructor: literal expectations per vector plus
// an arithmetic reference (q*d + r) checked whenever valid is high.
// Check-port vectors are exercised when DIV_RECON_CHECK_EN is defined.
module tb_div_reconstructor;
  import div_recon_pkg::*;

  localparam int unsigned W      = 32;
  localparam time         PERIOD = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;

  div_reconstructor_if #(.WIDTH(W)) bus ();

  div_reconstructor #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #(PERIOD/2) clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_div     = '0;
  logic           exp_mm      = 1'b0;
  logic           model_armed = 1'b0;
  time            t_launch    = 0;

  typedef struct {
    logic signed [W-1:0]   d;
    logic signed [W-1:0]   q;
    logic signed [W-1:0]   r;
    logic        [2*W-1:0] lit;
    logic        [2*W-1:0] o2;
    logic                  lit_mm;
  } vec_t;

  function automatic logic [2*W-1:0] model(input logic signed [W-1:0] d,
                                           input logic signed [W-1:0] q,
                                           input logic signed [W-1:0] r);
    longint p;
    p = longint'(q) * longint'(d) + longint'(r);
    return 64'(p);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference comparison on every cycle the result is final.
  always @(negedge clock) begin
    if (!reset && model_armed && bus.valid === 1'b1) begin
      check("model_dividend", bus.dividend, exp_div);
`ifdef DIV_RECON_CHECK_EN
      check("model_mismatch", 64'(bus.mismatch), 64'(exp_mm));
`endif
    end
  end

  task automatic drive(input vec_t v);
    bus.opera1 = v.d;
    bus.result = '0;
    bus.result[rem_offset(W) +: W] = v.r;
    bus.result[QUO_OFFSET +: W]    = v.q;
`ifdef DIV_RECON_CHECK_EN
    bus.opera2 = v.o2;
`endif
  endtask

  task automatic launch(input vec_t v);
    @(negedge clock);
    drive(v);
    bus.start = 1'b1;
    @(posedge clock);
    t_launch = $time;
    #1;
    exp_div     = model(v.d, v.q, v.r);
    exp_mm      = (model(v.d, v.q, v.r) != v.o2);
    model_armed = 1'b1;
    check("valid_drop_at_launch", 64'(bus.valid), 64'd0);
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // valid must first appear after edge launch+W+1 (cycle W+2).
  task automatic wait_done(input vec_t v);
    int n;
    n = 0;
    while (bus.valid !== 1'b1 && n <= int'(W) + 8) begin
      @(posedge clock);
      #1;
      n = int'(($time - t_launch) / PERIOD);
    end
    check("latency_edges", 64'(n), 64'(W + 1));
    check("literal_dividend", bus.dividend, v.lit);
`ifdef DIV_RECON_CHECK_EN
    check("literal_mismatch", 64'(bus.mismatch), 64'(v.lit_mm));
`endif
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    bus.start  = 1'b0;
    bus.opera1 = '0;
    bus.result = '0;
`ifdef DIV_RECON_CHECK_EN
    bus.opera2 = '0;
`endif
    vecs.push_back('{32'sd2,  32'sd3,  32'sd1,  64'd7, 64'd7, 1'b0});
    vecs.push_back('{32'sd2,  -32'sd3, -32'sd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0});
    vecs.push_back('{-32'sd2, -32'sd3, 32'sd1,  64'd7, 64'd7, 1'b0});
    vecs.push_back('{-32'sd2, 32'sd3,  -32'sd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0});
    vecs.push_back('{32'sh8000_0000, 32'sh8000_0000, 32'sd0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0});
    vecs.push_back('{32'sd0,  32'sd123, 32'sd5, 64'd5, 64'd5, 1'b0});
    vecs.push_back('{32'sd7,  -32'sd100, -32'sd3, 64'hFFFF_FFFF_FFFF_FD41, 64'hFFFF_FFFF_FFFF_FD41, 1'b0});
    vecs.push_back('{32'sd2,  32'sd3,  32'sd1,  64'd7, 64'd8, 1'b1});

    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", 64'(bus.valid), 64'd0);
    check("reset_dividend", bus.dividend, 64'd0);
`ifdef DIV_RECON_CHECK_EN
    check("reset_mismatch", 64'(bus.mismatch), 64'd0);
`endif
    @(negedge clock);
    reset = 1'b0;

    // Back-to-back: each launch lands on the first DONE cycle of the previous op.
    foreach (vecs[i]) begin
      launch(vecs[i]);
      wait_done(vecs[i]);
    end

    // Reset in the middle of MUL.
    v = vecs[0];
    launch(v);
    while (($time - t_launch) / PERIOD < 10) @(posedge clock);
    #1;
    reset = 1'b1;
    model_armed = 1'b0;
    #1;
    check("midreset_valid", 64'(bus.valid), 64'd0);
    check("midreset_dividend", bus.dividend, 64'd0);
    check("midreset_state", 64'(dut.state), 64'(IDLE));
    check("midreset_acc", dut.acc, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Fresh launch after reset.
    v = vecs[6];
    launch(v);
    wait_done(v);

    // Start toggle and input changes during MUL are ignored.
    v = vecs[1];
    launch(v);
    repeat (4) @(negedge clock);
    bus.start  = 1'b1;
    bus.opera1 = 32'd99;
    bus.result = 64'h0000_0011_0000_0022;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(v);
    repeat (3) @(negedge clock);
    check("hold_valid", 64'(bus.valid), 64'd1);
    check("hold_dividend", bus.dividend, v.lit);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(PERIOD * 2000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
